// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared definitions for the processor control slice.
//   state_t      - fetch/execute sequencer states
//   SEL_*        - C-bus source select codes
//   SEL_W_DEF    - default width of the C-bus select field
//   sel_for()    - C-bus source that each state drives
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_AR,
    ST_MEM_WAIT,
    ST_LATCH_IR,
    ST_EXEC,
    ST_BRANCH,
    ST_FAULT
  } state_t;

  localparam int unsigned SEL_W_DEF = 2;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_PC   = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_ALU  = 2'd3;

  // Only the states that write a register drive the C bus.
  function automatic logic [1:0] sel_for(input state_t st);
    case (st)
      ST_LOAD_AR:  sel_for = SEL_PC;
      ST_LATCH_IR: sel_for = SEL_MEM;
      ST_BRANCH:   sel_for = SEL_ALU;
      default:     sel_for = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// wait_timer: counts consecutive memory-wait cycles.
//   clk, reset  - clock, asynchronous active-low reset
//   clr         - restart the count at zero
//   en          - count this cycle (memory not ready)
//   expired     - this enabled cycle is the WAIT_MAX-th one
module wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  // Combinational so the FSM can leave MEM_WAIT on the same edge that
  // closes the last tolerated cycle.
  assign expired = en && (count == LIMIT);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM sequencing the register datapath through
// fetch and execute.
//   clk, reset        - clock, asynchronous active-low reset
//   start             - begin fetching (IDLE only)
//   halt_req          - return to IDLE after the current instruction
//   mem_ready         - instruction word valid on the C bus
//   exec_done         - execute unit finished (EXEC only)
//   branch_taken      - qualifies exec_done: ALU result is the new PC
//   mem_req           - memory read request
//   ar_we, ir_we      - address / instruction register write enables
//   pc_inc, pc_we     - PC increment / PC load from C bus (never together)
//   bus_sel           - C-bus source (NONE/PC/MEM/ALU)
//   exec_start        - one-cycle pulse launching execute
//   busy              - not in IDLE or FAULT
//   fault             - sticky memory timeout flag
//   fetch_count       - completed fetches, wrapping
module fetch_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned SEL_W    = SEL_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic                mem_ready,
  input  logic                exec_done,
  input  logic                branch_taken,
  output logic                mem_req,
  output logic                ar_we,
  output logic                ir_we,
  output logic                pc_inc,
  output logic                pc_we,
  output logic [SEL_W-1:0]    bus_sel,
  output logic                exec_start,
  output logic                busy,
  output logic                fault,
  output logic [DATA_LEN-1:0] fetch_count
);

  state_t state;
  state_t state_nxt;
  logic   timer_clr;
  logic   timer_en;
  logic   timer_expired;

  assign timer_clr = (state == ST_LOAD_AR);
  assign timer_en  = (state == ST_MEM_WAIT) && !mem_ready;

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_LOAD_AR;
      ST_LOAD_AR:  state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        // A ready word in the last tolerated cycle beats the timeout.
        if (mem_ready)          state_nxt = ST_LATCH_IR;
        else if (timer_expired) state_nxt = ST_FAULT;
      end
      ST_LATCH_IR: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
          if (halt_req)          state_nxt = ST_IDLE;
          else if (branch_taken) state_nxt = ST_BRANCH;
          else                   state_nxt = ST_LOAD_AR;
        end
      end
      ST_BRANCH:   state_nxt = ST_LOAD_AR;
      ST_FAULT:    state_nxt = ST_FAULT;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each flop holds the
  // Moore decode of the state being entered at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      mem_req     <= 1'b0;
      ar_we       <= 1'b0;
      ir_we       <= 1'b0;
      pc_inc      <= 1'b0;
      pc_we       <= 1'b0;
      bus_sel     <= '0;
      exec_start  <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state      <= state_nxt;
      mem_req    <= (state_nxt == ST_MEM_WAIT);
      ar_we      <= (state_nxt == ST_LOAD_AR);
      ir_we      <= (state_nxt == ST_LATCH_IR);
      pc_inc     <= (state_nxt == ST_LATCH_IR);
      pc_we      <= (state_nxt == ST_BRANCH);
      bus_sel    <= SEL_W'(sel_for(state_nxt));
      // EXEC is only ever entered from LATCH_IR, so this marks its first cycle.
      exec_start <= (state == ST_LATCH_IR);
      busy       <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
      fault      <= (state_nxt == ST_FAULT);
      if (state == ST_LATCH_IR) begin
        fetch_count <= fetch_count + DATA_LEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset, start, halt_req, mem_ready, exec_done, branch_taken;

  logic        mem_req, ar_we, ir_we, pc_inc, pc_we, exec_start, busy, fault;
  logic [1:0]  bus_sel;
  logic [15:0] fetch_count;

  logic        mem_req_4, ar_we_4, ir_we_4, pc_inc_4, pc_we_4;
  logic        exec_start_4, busy_4, fault_4;
  logic [1:0]  bus_sel_4;
  logic [3:0]  fetch_count_4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.DATA_LEN(16), .WAIT_MAX(15), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .mem_ready(mem_ready), .exec_done(exec_done), .branch_taken(branch_taken),
    .mem_req(mem_req), .ar_we(ar_we), .ir_we(ir_we), .pc_inc(pc_inc),
    .pc_we(pc_we), .bus_sel(bus_sel), .exec_start(exec_start), .busy(busy),
    .fault(fault), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.DATA_LEN(4), .WAIT_MAX(15), .SEL_W(2)) dut4 (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .mem_ready(mem_ready), .exec_done(exec_done), .branch_taken(branch_taken),
    .mem_req(mem_req_4), .ar_we(ar_we_4), .ir_we(ir_we_4), .pc_inc(pc_inc_4),
    .pc_we(pc_we_4), .bus_sel(bus_sel_4), .exec_start(exec_start_4),
    .busy(busy_4), .fault(fault_4), .fetch_count(fetch_count_4)
  );

  // {mem_req, ar_we, ir_we, pc_inc, pc_we, bus_sel[1:0], exec_start, busy, fault}
  localparam logic [9:0] O_IDLE  = 10'b00000_00_000;
  localparam logic [9:0] O_LOAD  = 10'b01000_01_010;
  localparam logic [9:0] O_WAIT  = 10'b10000_00_010;
  localparam logic [9:0] O_LATCH = 10'b00110_10_010;
  localparam logic [9:0] O_EXEC1 = 10'b00000_00_110;
  localparam logic [9:0] O_EXEC  = 10'b00000_00_010;
  localparam logic [9:0] O_BRAN  = 10'b00001_11_010;
  localparam logic [9:0] O_FAULT = 10'b00000_00_001;

  logic [9:0] outs16, outs4;
  assign outs16 = {mem_req, ar_we, ir_we, pc_inc, pc_we, bus_sel, exec_start, busy, fault};
  assign outs4  = {mem_req_4, ar_we_4, ir_we_4, pc_inc_4, pc_we_4, bus_sel_4,
                   exec_start_4, busy_4, fault_4};

  logic inv_ok;
  assign inv_ok = !(pc_inc && pc_we) && $onehot0({ar_we, ir_we, pc_we}) &&
                  ((ar_we || ir_we || pc_we) || (bus_sel == 2'd0));

  typedef struct {
    logic       st, hr, mr, ed, bt;
    logic [9:0] exp_outs;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, hr, mr, ed, bt,
                     input logic [9:0] e, input logic [15:0] c);
    vec_t v;
    v.st = st; v.hr = hr; v.mr = mr; v.ed = ed; v.bt = bt;
    v.exp_outs = e; v.exp_cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [9:0] e, input logic [15:0] c);
    logic [3:0] c4;
    c4 = c[3:0];
    vectors++;
    if (!((outs16 === e) && (fetch_count === c) && (outs4 === e) &&
          (fetch_count_4 === c4) && (inv_ok === 1'b1))) begin
      miscompares++;
      $display("FAIL %s: got outs=%b cnt=%0d outs4=%b cnt4=%0d inv=%b, want outs=%b cnt=%0d cnt4=%0d",
               name, outs16, fetch_count, outs4, fetch_count_4, inv_ok, e, c, c4);
    end
  endtask

  task automatic step(input string name, input logic st, hr, mr, ed, bt,
                      input logic [9:0] e, input logic [15:0] c);
    start = st; halt_req = hr; mem_ready = mr; exec_done = ed; branch_taken = bt;
    @(posedge clk);
    #1;
    check(name, e, c);
  endtask

  initial begin
    reset = 1'b0;
    start = 0; halt_req = 0; mem_ready = 0; exec_done = 0; branch_taken = 0;

    // Three non-branch instructions, zero-wait memory, exec_done at once.
    add(1,0,0,0,0, O_LOAD, 0);
    add(0,0,1,0,0, O_WAIT, 0);
    add(0,0,1,0,0, O_LATCH, 0);
    add(0,0,1,0,0, O_EXEC1, 1);
    add(0,0,0,1,0, O_LOAD, 1);
    add(0,0,1,0,0, O_WAIT, 1);
    add(0,0,1,0,0, O_LATCH, 1);
    add(0,0,0,0,0, O_EXEC1, 2);
    add(0,0,0,1,0, O_LOAD, 2);
    add(0,0,1,0,0, O_WAIT, 2);
    add(0,0,1,0,0, O_LATCH, 2);
    add(0,0,0,0,0, O_EXEC1, 3);
    // Slow execute; start ignored outside IDLE; then a taken branch.
    add(0,0,0,0,0, O_EXEC, 3);
    add(1,0,1,0,0, O_EXEC, 3);
    add(0,0,0,1,1, O_BRAN, 3);
    add(0,0,1,0,0, O_LOAD, 3);
    add(0,0,0,0,0, O_WAIT, 3);
    // Memory ready after 4 not-ready cycles.
    for (int i = 0; i < 4; i++) add(0,0,0,0,0, O_WAIT, 3);
    add(0,0,1,0,0, O_LATCH, 3);
    add(0,0,0,0,0, O_EXEC1, 4);
    // Halt with a simultaneous branch: branch discarded.
    add(0,1,0,1,1, O_IDLE, 4);
    add(0,0,0,1,1, O_IDLE, 4);
    add(0,0,1,0,0, O_IDLE, 4);
    // Memory never ready: fault at the edge closing the 15th wait cycle.
    add(1,0,0,0,0, O_LOAD, 4);
    add(0,0,0,0,0, O_WAIT, 4);
    for (int i = 0; i < 14; i++) add(0,0,0,0,0, O_WAIT, 4);
    add(0,0,0,0,0, O_FAULT, 4);
    add(1,0,1,1,0, O_FAULT, 4);
    add(0,1,1,1,1, O_FAULT, 4);

    #3;
    check("reset_async", O_IDLE, 0);
    @(posedge clk); @(posedge clk); #1;
    check("reset_hold", O_IDLE, 0);
    reset = 1'b1;
    step("idle_no_start", 0,0,0,0,0, O_IDLE, 0);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].st, vecs[i].hr, vecs[i].mr,
           vecs[i].ed, vecs[i].bt, vecs[i].exp_outs, vecs[i].exp_cnt);
    end

    // Fault leaves only through reset, cleared without a clock edge.
    #2 reset = 1'b0;
    #1 check("fault_reset_clear", O_IDLE, 0);
    #1 reset = 1'b1;

    // mem_ready in the 15th not-ready-able cycle beats the timeout.
    step("late_start", 1,0,0,0,0, O_LOAD, 0);
    step("late_wait0", 0,0,0,0,0, O_WAIT, 0);
    for (int i = 0; i < 14; i++) step($sformatf("late_wait%0d", i + 1), 0,0,0,0,0, O_WAIT, 0);
    step("late_ready_wins", 0,0,1,0,0, O_LATCH, 0);
    step("late_exec", 0,0,0,0,0, O_EXEC1, 1);
    step("late_next", 0,0,0,1,0, O_LOAD, 1);
    step("late_wait", 0,0,0,0,0, O_WAIT, 1);

    // Reset in MEM_WAIT aborts immediately and clears the count.
    #2 reset = 1'b0;
    #1 check("abort_async", O_IDLE, 0);
    start = 1; mem_ready = 1;
    @(posedge clk); #1;
    check("abort_hold", O_IDLE, 0);
    reset = 1'b1;

    // 17 fetches: 4-bit counter wraps to 1.
    step("wrap_start", 1,0,0,0,0, O_LOAD, 0);
    for (int i = 1; i <= 17; i++) begin
      step($sformatf("wrap%0d_wait", i),  0,0,1,0,0, O_WAIT, 16'(i - 1));
      step($sformatf("wrap%0d_latch", i), 0,0,1,0,0, O_LATCH, 16'(i - 1));
      step($sformatf("wrap%0d_exec", i),  0,0,0,0,0, O_EXEC1, 16'(i));
      step($sformatf("wrap%0d_done", i),  0,(i == 17),0,1,0,
           (i == 17) ? O_IDLE : O_LOAD, 16'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM that sequences the processor's register datapath through fetch and execute. It drives the C-bus source select, the address-register and instruction-register write enables, and the program counter's `inc`/`WE` controls. It handshakes with instruction memory and the execute unit, and guarantees the PC never sees `inc` and `WE` in the same cycle. It sits between the top-level control and the register file, replacing ad-hoc enable generation.

## Interface
- `DATA_LEN`, 16: width of `fetch_count`.
- `WAIT_MAX`, 15: memory-wait cycles tolerated before fault; legal range 1..255.
- `SEL_W`, 2: width of `bus_sel`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin fetching; sampled only in IDLE.
- `halt_req`  in  1  stop after the current instruction; sampled with `exec_done`.
- `mem_ready`  in  1  instruction word valid on the C bus this cycle.
- `exec_done`  in  1  execute unit finished the current instruction.
- `branch_taken`  in  1  qualifies `exec_done`; ALU result is the new PC.
- `mem_req`  out  1  memory read request.
- `ar_we`  out  1  address-register write enable.
- `ir_we`  out  1  instruction-register write enable.
- `pc_inc`  out  1  PC increment.
- `pc_we`  out  1  PC load from C bus.
- `bus_sel`  out  SEL_W  C-bus source: 0 NONE, 1 PC, 2 MEM, 3 ALU.
- `exec_start`  out  1  one-cycle pulse launching execute.
- `busy`  out  1  high in every state except IDLE and FAULT.
- `fault`  out  1  sticky memory-timeout flag.
- `fetch_count`  out  DATA_LEN  completed fetches, wraps modulo 2^DATA_LEN.

## Operation
- States: IDLE, LOAD_AR, MEM_WAIT, LATCH_IR, EXEC, BRANCH, FAULT.
- Outputs are Moore, decoded from the state register only. `fetch_count`, `fault` and the wait counter are registered.
- IDLE: all strobes 0, `bus_sel`=NONE. Goes to LOAD_AR when `start`=1.
- LOAD_AR (1 cycle): `bus_sel`=PC, `ar_we`=1. Goes to MEM_WAIT.
- MEM_WAIT: `mem_req`=1.
  - `mem_ready`=1: go to LATCH_IR.
  - Otherwise increment the wait counter (cleared on entry).
  - On the WAIT_MAX-th consecutive not-ready cycle, go to FAULT.
  - `mem_ready` in that same cycle wins over the timeout.
- LATCH_IR (1 cycle): `bus_sel`=MEM, `ir_we`=1, `pc_inc`=1, `fetch_count`+1. Goes to EXEC.
- EXEC: `exec_start`=1 on the first EXEC cycle only. Waits for `exec_done`, then:
  - `halt_req`=1 → IDLE. Halt has priority; a simultaneous branch is discarded.
  - `branch_taken`=1 → BRANCH.
  - Otherwise → LOAD_AR.
- BRANCH (1 cycle): `bus_sel`=ALU, `pc_we`=1. Goes to LOAD_AR.
- FAULT: `fault`=1, all strobes 0. Leaves only on reset.
- Invariants:
  - `pc_inc` and `pc_we` are never both 1.
  - `ar_we`, `ir_we` and `pc_we` are mutually exclusive.
  - `bus_sel`=NONE whenever no write enable is active.
- `start` outside IDLE is ignored. `exec_done` outside EXEC is ignored.

## Timing
- Reset (`reset`=0) forces IDLE immediately, without waiting for a clock edge. While reset is low and after release:
  - All outputs 0, `bus_sel`=NONE.
  - `fetch_count`=0, `fault`=0, wait counter 0.
- Reset mid-operation aborts any fetch or execute; no partial strobe survives.
- `start` sampled at edge N: LOAD_AR during cycle N+1, MEM_WAIT from N+2.
- Zero-wait memory: LOAD_AR → MEM_WAIT → LATCH_IR → EXEC gives `exec_start` 3 cycles after LOAD_AR.
- Fetch-to-fetch minimum, non-branch with `exec_done` in the first EXEC cycle: 4 cycles. With a branch: 5.
- Timeout: FAULT is entered at the edge closing the WAIT_MAX-th not-ready MEM_WAIT cycle.
- `fetch_count` updates at the edge leaving LATCH_IR.

## Structure
- Shared package `proc_ctrl_pkg`: state enum/encoding, bus-select codes (SEL_NONE/PC/MEM/ALU), SEL_W default.
- Sub-module `wait_timer`:
  - Inputs: `clr`, `en`.
  - Output: `expired`, asserted when the count reaches WAIT_MAX-1 and `en` is high.
  - Width: clog2(WAIT_MAX+1).
  - Async active-low reset, same `clk`/`reset`.
- Top file holds the FSM, output decode and `fetch_count`.

## Test plan
- Reset then `start`, `mem_ready` held 1, `exec_done` on the first EXEC cycle, no branch, 3 instructions → `fetch_count`=3, `pc_inc` pulses 3, `pc_inc`/`pc_we` never overlap.
- `mem_ready` delayed 4 cycles, WAIT_MAX=15 → `mem_req` high for 5 cycles, no fault, `ir_we` one cycle after ready.
- `mem_ready` never asserted, WAIT_MAX=15 → `fault`=1 after exactly 15 MEM_WAIT cycles, strobes 0, `busy`=0, stays until reset.
- `exec_done`+`branch_taken` → one cycle of `pc_we`=1 with `bus_sel`=3, then `ar_we` with `bus_sel`=1.
- `exec_done`+`halt_req`+`branch_taken` together → IDLE, no `pc_we`; `reset` pulsed low in MEM_WAIT → immediate IDLE, `fetch_count`=0.
- DATA_LEN=4, 17 fetches → `fetch_count`=1 (wrap).
